// File: rtl/decrypt_pkg.sv
// Shared definitions for the receive-side decrypter: ciphertext field layout,
// FSM states, function codes and the key/group helpers.
package decrypt_pkg;

  localparam int WORD_W = 76;
  localparam int PAY_W  = 60;
  localparam int GRP_W  = 15;

  localparam int PAR_BIT = 75;
  localparam int R9_HI   = 74;
  localparam int R9_LO   = 66;
  localparam int R6_HI   = 65;
  localparam int R6_LO   = 60;
  localparam int PAY_HI  = 59;
  localparam int PAY_LO  = 0;

  localparam logic [5:0] ROT_MOD = 6'd60;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UNMASK = 2'd1,
    UNPERM = 2'd2,
    OUT    = 2'd3
  } state_t;

  localparam logic [1:0] F0 = 2'd0;
  localparam logic [1:0] F1 = 2'd1;
  localparam logic [1:0] F2 = 2'd2;
  localparam logic [1:0] F3 = 2'd3;

  // The 15-bit salt chunk {rand6, rand9} tiled across the payload width.
  function automatic logic [PAY_W-1:0] expand_key(input logic [5:0] rand6,
                                                  input logic [8:0] rand9);
    return {4{rand6, rand9}};
  endfunction

  function automatic logic [PAY_W-1:0] reverse_groups(input logic [PAY_W-1:0] v);
    return {v[GRP_W-1:0], v[2*GRP_W-1:GRP_W], v[3*GRP_W-1:2*GRP_W], v[4*GRP_W-1:3*GRP_W]};
  endfunction

endpackage

// File: rtl/decrypt_rotr60.sv
// Combinational 60-bit rotate-right; amount must already be reduced to 0..59.
module decrypt_rotr60
  import decrypt_pkg::*;
(
  input  logic [PAY_W-1:0] value,
  input  logic [5:0]       amount,
  output logic [PAY_W-1:0] result
);

  logic [6:0] back_amount;

  // A zero amount makes the left shift 60, which yields 0 and leaves value intact.
  assign back_amount = 7'd60 - {1'b0, amount};
  assign result      = (value >> amount) | (value << back_amount);

endmodule

// File: rtl/decrypter.sv
// Decrypts one 76-bit ciphertext into 60-bit plaintext through UNMASK/UNPERM steps.
// Latency 3 cycles from acceptance to out_valid; one word in flight, held until out_ready.
module decrypter
  import decrypt_pkg::*;
(
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] data_to_be_decrypt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PAY_W-1:0]  output_decrypted,
  output logic              parity_err
);

  state_t state;
  state_t next_state;

  logic [5:0]       rand6_q;
  logic [8:0]       rand9_q;
  logic [PAY_W-1:0] work_q;

  logic             accept;
  logic [1:0]       func;
  logic [5:0]       rot_amt;
  logic [PAY_W-1:0] key;
  logic [PAY_W-1:0] step_a;
  logic [PAY_W-1:0] step_b;
  logic [PAY_W-1:0] rotated;
  logic             word_parity;

  assign func        = rand6_q[1:0];
  assign key         = expand_key(rand6_q, rand9_q);
  assign rot_amt     = (rand6_q < ROT_MOD) ? rand6_q : rand6_q - ROT_MOD;
  assign word_parity = data_to_be_decrypt[PAR_BIT] ^ (^data_to_be_decrypt[R9_HI:PAY_LO]);

  decrypt_rotr60 u_rotr (
    .value  (work_q),
    .amount (rot_amt),
    .result (rotated)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept     = 1'b1;
          next_state = UNMASK;
        end
      end
      UNMASK:  next_state = UNPERM;
      UNPERM:  next_state = OUT;
      OUT: begin
        if (out_ready) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    step_a = work_q;
    step_b = work_q;
    case (func)
      F0: step_a = work_q ^ key;
      F1: begin
        step_a = work_q ^ key;
        step_b = rotated;
      end
      F2: step_a = work_q - key;
      F3: begin
        step_a = reverse_groups(work_q);
        step_b = work_q ^ key;
      end
      default: begin
        step_a = work_q;
        step_b = work_q;
      end
    endcase
  end

  // in_ready is registered off next_state so it is low throughout reset and
  // rises the cycle after the output handshake.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      in_ready         <= 1'b0;
      out_valid        <= 1'b0;
      output_decrypted <= '0;
      parity_err       <= 1'b0;
      rand6_q          <= '0;
      rand9_q          <= '0;
      work_q           <= '0;
    end else begin
      in_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            rand9_q    <= data_to_be_decrypt[R9_HI:R9_LO];
            rand6_q    <= data_to_be_decrypt[R6_HI:R6_LO];
            work_q     <= data_to_be_decrypt[PAY_HI:PAY_LO];
            parity_err <= word_parity;
          end
        end
        UNMASK: work_q <= step_a;
        UNPERM: begin
          output_decrypted <= parity_err ? '0 : step_b;
          out_valid        <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
